// File: rtl/fetch_unit.sv
// Instruction fetch front-end: owns the PC, prefetches into a 2-entry queue and
// arbitrates single load/store accesses onto the shared memory port.
`timescale 1ns/1ps
module fetch_unit #(
  parameter int N        = 16,
  parameter int M        = 1024,
  parameter int RESET_PC = 0
) (
  input  logic         clk,
  input  logic         rst,
  output logic [N-1:0] mem_address,
  output logic [N-1:0] mem_in,
  output logic         mem_write_en,
  input  logic [N-1:0] mem_out,
  input  logic         redirect,
  input  logic [N-1:0] redirect_pc,
  output logic         instr_valid,
  input  logic         instr_ready,
  output logic [N-1:0] instr,
  output logic [N-1:0] instr_pc,
  input  logic         data_req,
  input  logic         data_we,
  input  logic [N-1:0] data_addr,
  input  logic [N-1:0] data_wdata,
  output logic [N-1:0] data_rdata,
  output logic         data_ack
);

  // state      | meaning
  // FETCH      | memory port used for instruction prefetch; accepts data_req
  // DRD        | load address on the port, result captured at end of cycle
  // DWR_SETUP  | store address/data driven, strobe low (setup cycle)
  // DWR_STROBE | write strobe high for exactly one cycle
  // DACK       | strobe low, address/data held (hold cycle); ack pulse out
  typedef enum logic [2:0] {FETCH, DRD, DWR_SETUP, DWR_STROBE, DACK} state_t;

  state_t       state, state_d;
  logic [N-1:0] pc, pc_next, addr_q, wdata_q, rdata_q, fetch_word;
  logic         we_q, wen_q, ack_q;
  logic [N-1:0] q_pc   [2];
  logic [N-1:0] q_word [2];
  logic         rd_ptr, wr_idx;
  logic [1:0]   count;
  logic         push, pop;

  always_ff @(posedge clk) begin
    if (rst) state <= FETCH;
    else     state <= state_d;
  end

  always_comb begin
    state_d     = state;
    mem_address = addr_q;
    case (state)
      FETCH: begin
        mem_address = pc;
        if (data_req) state_d = data_we ? DWR_SETUP : DRD;
      end
      DRD:        state_d = DACK;
      DWR_SETUP:  state_d = DWR_STROBE;
      DWR_STROBE: state_d = DACK;
      DACK:       state_d = FETCH;
      default:    state_d = FETCH;
    endcase
  end

  // Address 0 always reads as zero, both for fetched words and for loads.
  assign fetch_word = (pc == '0) ? '0 : mem_out;
  assign pc_next    = (pc == N'(M - 1)) ? '0 : pc + N'(1);
  assign pop        = (count != 2'd0) && instr_ready;
  assign push       = (state == FETCH) && !data_req && !redirect &&
                      ((count < 2'd2) || pop);
  // With two slots the tail is rd_ptr when empty or full, the other slot otherwise.
  assign wr_idx     = rd_ptr ^ count[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      pc      <= N'(RESET_PC);
      count   <= 2'd0;
      rd_ptr  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      wen_q   <= 1'b0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      if (redirect) begin
        pc    <= redirect_pc;
        count <= 2'd0;
      end else begin
        if (push) pc <= pc_next;
        if (pop)  rd_ptr <= ~rd_ptr;
        count <= count + {1'b0, push} - {1'b0, pop};
      end
      if (state == FETCH && data_req) begin
        addr_q  <= data_addr;
        wdata_q <= data_wdata;
        we_q    <= data_we;
      end
      if (state == DRD) rdata_q <= (addr_q == '0) ? '0 : mem_out;
      wen_q <= (state_d == DWR_STROBE);
      ack_q <= (state_d == DACK);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      q_pc[wr_idx]   <= pc;
      q_word[wr_idx] <= fetch_word;
    end
  end

  assign mem_in       = wdata_q;
  assign mem_write_en = wen_q;
  assign data_ack     = ack_q;
  assign data_rdata   = rdata_q;
  assign instr_valid  = (count != 2'd0);
  assign instr        = q_word[rd_ptr];
  assign instr_pc     = q_pc[rd_ptr];

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: behavioural memory on the port plus a shadow memory and
// expected-PC scoreboard for the instruction stream and data accesses.
`timescale 1ns/1ps
module tb_fetch_unit;
  localparam int N   = 16;
  localparam int M   = 1024;
  localparam int RPC = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] mem_address, mem_in, mem_out;
  logic         mem_write_en;
  logic         redirect = 1'b0;
  logic [N-1:0] redirect_pc = '0;
  logic         instr_valid, instr_ready = 1'b0;
  logic [N-1:0] instr, instr_pc;
  logic         data_req = 1'b0, data_we = 1'b0;
  logic [N-1:0] data_addr = '0, data_wdata = '0, data_rdata;
  logic         data_ack;

  int tests = 0;
  int fails = 0;

  logic [N-1:0] mem     [0:M-1];
  logic [N-1:0] ref_mem [0:M-1];

  always #5 clk = ~clk;

  fetch_unit #(.N(N), .M(M), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst),
    .mem_address(mem_address), .mem_in(mem_in), .mem_write_en(mem_write_en),
    .mem_out(mem_out),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_rdata(data_rdata), .data_ack(data_ack)
  );

  // Memory: combinational read (address 0 reads 0), write on strobe rising edge.
  assign mem_out = (mem_address == '0) ? '0 : mem[mem_address[9:0]];
  initial begin
    for (int i = 0; i < M; i++) mem[i] = N'($urandom);
    mem[4] = 16'h1111; mem[5] = 16'h2222; mem[6] = 16'h3333; mem[7] = 16'h4444;
    forever begin
      @(posedge mem_write_en);
      mem[mem_address[9:0]] = mem_in;
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N-1:0] inc_pc(input logic [N-1:0] p);
    return (p == N'(M - 1)) ? '0 : p + N'(1);
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    next();
    @(negedge clk);
    tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", instr_valid); end
    tests++; if (mem_write_en !== 1'b0) begin fails++; $display("FAIL reset_wen got %b want 0", mem_write_en); end
    tests++; if (data_ack !== 1'b0) begin fails++; $display("FAIL reset_ack got %b want 0", data_ack); end
    tests++; if (data_rdata !== 16'h0) begin fails++; $display("FAIL reset_rdata got %h want 0", data_rdata); end
    tests++; if (mem_address !== N'(RPC)) begin fails++; $display("FAIL reset_addr got %h want %h", mem_address, RPC); end
    tests++; if (mem_in !== 16'h0) begin fails++; $display("FAIL reset_memin got %h want 0", mem_in); end
  endtask

  task automatic test_first_fetch();
    logic [N-1:0] exp_w [4];
    exp_w[0] = 16'h1111; exp_w[1] = 16'h2222; exp_w[2] = 16'h3333; exp_w[3] = 16'h4444;
    next();
    rst = 1'b0;
    instr_ready = 1'b1;
    @(negedge clk);
    tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL first_c1_valid got %b want 0", instr_valid); end
    tests++; if (mem_address !== N'(RPC)) begin fails++; $display("FAIL first_c1_addr got %h want %h", mem_address, RPC); end
    for (int k = 0; k < 4; k++) begin
      next();
      @(negedge clk);
      tests++; if (instr_valid !== 1'b1) begin fails++; $display("FAIL first_valid[%0d] got %b want 1", k, instr_valid); end
      tests++; if (instr !== exp_w[k]) begin fails++; $display("FAIL first_instr[%0d] got %h want %h", k, instr, exp_w[k]); end
      tests++; if (instr_pc !== N'(RPC + k)) begin fails++; $display("FAIL first_pc[%0d] got %h want %h", k, instr_pc, RPC + k); end
    end
    next();
  endtask

  task automatic test_stall();
    instr_ready = 1'b0;
    redirect = 1'b1; redirect_pc = 16'h0010;
    next();
    redirect = 1'b0;
    repeat (4) next();
    @(negedge clk);
    tests++; if (instr_valid !== 1'b1) begin fails++; $display("FAIL stall_valid got %b want 1", instr_valid); end
    tests++; if (instr_pc !== 16'h0010) begin fails++; $display("FAIL stall_head got %h want 0010", instr_pc); end
    tests++; if (mem_address !== 16'h0012) begin fails++; $display("FAIL stall_pc got %h want 0012", mem_address); end
    next();
    instr_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      tests++; if (instr_valid !== 1'b1 || instr_pc !== N'(16 + k))
        begin fails++; $display("FAIL stall_release_pc[%0d] got %h (v=%b) want %h", k, instr_pc, instr_valid, 16 + k); end
      tests++; if (instr !== ref_mem[16 + k]) begin fails++; $display("FAIL stall_release_word[%0d] got %h want %h", k, instr, ref_mem[16 + k]); end
      next();
    end
  endtask

  task automatic test_store_load();
    instr_ready = 1'b0;
    redirect = 1'b1; redirect_pc = 16'h0040;
    next();
    redirect = 1'b0;
    next();
    data_req = 1'b1; data_we = 1'b1; data_addr = 16'd9; data_wdata = 16'hBEEF;
    ref_mem[9] = 16'hBEEF;
    @(negedge clk);
    tests++; if (mem_address !== 16'h0041) begin fails++; $display("FAIL st_t0_addr got %h want 0041", mem_address); end
    next();
    @(negedge clk);
    tests++; if (mem_write_en !== 1'b0 || mem_address !== 16'd9 || mem_in !== 16'hBEEF)
      begin fails++; $display("FAIL st_setup got wen=%b addr=%h in=%h want 0/0009/beef", mem_write_en, mem_address, mem_in); end
    next();
    @(negedge clk);
    tests++; if (mem_write_en !== 1'b1 || data_ack !== 1'b0 || mem_address !== 16'd9)
      begin fails++; $display("FAIL st_strobe got wen=%b ack=%b addr=%h want 1/0/0009", mem_write_en, data_ack, mem_address); end
    next();
    @(negedge clk);
    tests++; if (data_ack !== 1'b1 || mem_write_en !== 1'b0 || mem_address !== 16'd9 || mem_in !== 16'hBEEF)
      begin fails++; $display("FAIL st_ack got ack=%b wen=%b addr=%h in=%h want 1/0/0009/beef", data_ack, mem_write_en, mem_address, mem_in); end
    next();
    data_we = 1'b0;
    @(negedge clk);
    tests++; if (mem[9] !== ref_mem[9]) begin fails++; $display("FAIL st_mem got %h want %h", mem[9], ref_mem[9]); end
    tests++; if (data_ack !== 1'b0) begin fails++; $display("FAIL st_ack_pulse got %b want 0", data_ack); end
    next();
    @(negedge clk);
    tests++; if (data_ack !== 1'b0 || mem_address !== 16'd9) begin fails++; $display("FAIL ld_drd got ack=%b addr=%h want 0/0009", data_ack, mem_address); end
    next();
    @(negedge clk);
    tests++; if (data_ack !== 1'b1 || data_rdata !== 16'hBEEF) begin fails++; $display("FAIL ld_ack got ack=%b rdata=%h want 1/beef", data_ack, data_rdata); end
    next();
    data_req = 1'b0;
    instr_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      tests++; if (instr_valid !== 1'b1 || instr_pc !== N'(16'h40 + k) || instr !== ref_mem[16'h40 + k])
        begin fails++; $display("FAIL dat_stream[%0d] got pc=%h w=%h v=%b want %h/%h", k, instr_pc, instr, instr_valid, 16'h40 + k, ref_mem[16'h40 + k]); end
      next();
    end
  endtask

  task automatic test_redirect_full();
    instr_ready = 1'b0;
    repeat (3) next();
    redirect = 1'b1; redirect_pc = 16'h0020;
    next();
    redirect = 1'b0;
    instr_ready = 1'b1;
    @(negedge clk);
    tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL redir_flush got valid=%b pc=%h want 0", instr_valid, instr_pc); end
    for (int k = 0; k < 2; k++) begin
      next();
      @(negedge clk);
      tests++; if (instr_valid !== 1'b1 || instr_pc !== N'(16'h20 + k) || instr !== ref_mem[16'h20 + k])
        begin fails++; $display("FAIL redir_stream[%0d] got pc=%h w=%h v=%b want %h", k, instr_pc, instr, instr_valid, 16'h20 + k); end
    end
    next();
  endtask

  task automatic test_wrap();
    instr_ready = 1'b1;
    redirect = 1'b1; redirect_pc = N'(M - 1);
    next();
    redirect = 1'b0;
    next();
    @(negedge clk);
    tests++; if (instr_valid !== 1'b1 || instr_pc !== N'(M - 1) || instr !== ref_mem[M - 1])
      begin fails++; $display("FAIL wrap_last got pc=%h w=%h v=%b want %h", instr_pc, instr, instr_valid, M - 1); end
    next();
    @(negedge clk);
    tests++; if (instr_valid !== 1'b1 || instr_pc !== 16'h0 || instr !== 16'h0)
      begin fails++; $display("FAIL wrap_zero got pc=%h w=%h v=%b want 0000/0000", instr_pc, instr, instr_valid); end
    next();
    instr_ready = 1'b0;
    data_req = 1'b1; data_we = 1'b0; data_addr = 16'h0;
    next();
    next();
    @(negedge clk);
    tests++; if (data_ack !== 1'b1 || data_rdata !== 16'h0) begin fails++; $display("FAIL load_zero got ack=%b rdata=%h want 1/0000", data_ack, data_rdata); end
    next();
    data_req = 1'b0;
  endtask

  task automatic test_reset_mid_store();
    instr_ready = 1'b0;
    data_req = 1'b1; data_we = 1'b1; data_addr = 16'h0030; data_wdata = 16'h5A5A;
    ref_mem[16'h30] = 16'h5A5A;
    next();
    next();
    @(negedge clk);
    tests++; if (mem_write_en !== 1'b1) begin fails++; $display("FAIL rst_store_strobe got %b want 1", mem_write_en); end
    rst = 1'b1;
    next();
    rst = 1'b0;
    data_req = 1'b0;
    @(negedge clk);
    tests++; if (mem_address !== N'(RPC)) begin fails++; $display("FAIL rst_store_pc got %h want %h", mem_address, RPC); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      tests++; if (mem_write_en !== 1'b0 || data_ack !== 1'b0)
        begin fails++; $display("FAIL rst_store_quiet[%0d] got wen=%b ack=%b want 0/0", k, mem_write_en, data_ack); end
      next();
    end
    @(negedge clk);
    tests++; if (instr_valid !== 1'b1 || instr_pc !== N'(RPC)) begin fails++; $display("FAIL rst_store_head got pc=%h v=%b want %h", instr_pc, instr_valid, RPC); end
    tests++; if (mem[16'h30] !== ref_mem[16'h30]) begin fails++; $display("FAIL rst_store_commit got %h want %h", mem[16'h30], ref_mem[16'h30]); end
    next();
  endtask

  task automatic test_random();
    logic [N-1:0] exp_pc, tgt, op_addr;
    logic         op_active, op_we;
    int           ack_due, pops;
    op_active = 1'b0; op_we = 1'b0; op_addr = '0; ack_due = -10; pops = 0; tgt = '0;
    redirect = 1'b1; redirect_pc = 16'd100;
    next();
    redirect = 1'b0;
    exp_pc = 16'd100;
    for (int k = 0; k < 400; k++) begin
      instr_ready = 1'($urandom);
      if (op_active && k == ack_due + 1) begin
        op_active = 1'b0;
        data_req = 1'b0;
      end
      if (!op_active && ($urandom % 6) == 0) begin
        op_active  = 1'b1;
        op_we      = 1'($urandom);
        op_addr    = N'($urandom_range(850, 950));
        data_req   = 1'b1; data_we = op_we; data_addr = op_addr; data_wdata = N'($urandom);
        ack_due    = k + (op_we ? 3 : 2);
        if (op_we) ref_mem[op_addr] = data_wdata;
      end
      if (($urandom % 40) == 0) begin
        tgt = N'($urandom_range(16, 400));
        redirect = 1'b1; redirect_pc = tgt;
      end
      @(negedge clk);
      if (instr_valid === 1'b1 && instr_ready) begin
        pops++;
        tests++; if (instr_pc !== exp_pc || instr !== ref_mem[exp_pc])
          begin fails++; $display("FAIL rand_instr cyc %0d got pc=%h w=%h want %h/%h", k, instr_pc, instr, exp_pc, ref_mem[exp_pc]); end
        exp_pc = inc_pc(exp_pc);
      end
      tests++; if (data_ack !== (op_active && k == ack_due))
        begin fails++; $display("FAIL rand_ack cyc %0d got %b want %b", k, data_ack, (op_active && k == ack_due)); end
      if (op_active && k == ack_due && !op_we) begin
        tests++; if (data_rdata !== ref_mem[op_addr])
          begin fails++; $display("FAIL rand_load addr %h got %h want %h", op_addr, data_rdata, ref_mem[op_addr]); end
      end
      if (redirect) exp_pc = tgt;
      next();
      redirect = 1'b0;
    end
    data_req = 1'b0;
    tests++; if (pops < 50) begin fails++; $display("FAIL rand_progress got %0d pops want >= 50", pops); end
    repeat (3) next();
  endtask

  initial begin
    #1;
    for (int i = 0; i < M; i++) ref_mem[i] = mem[i];
    ref_mem[0] = '0;
    next();
    test_reset();
    test_first_fetch();
    test_stall();
    test_store_load();
    test_redirect_full();
    test_wrap();
    test_reset_mid_store();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Front-end stage that sits directly upstream of `memory`, driving its address, write-data and write-strobe inputs. It owns the program counter, prefetches instruction words into a 2-entry queue for decode, and arbitrates single data accesses (load/store) from execute onto the same memory port. Because `memory` reads combinationally and writes on the rising edge of its write enable, this block also generates a clean, setup-protected write strobe.

## Interface
- `N`, 16: word and address width; matches `memory`.
- `M`, 1024: memory depth in words; power of two.
- `RESET_PC`, 0: PC value loaded on reset.

- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `mem_address` out N: to `memory.address`.
- `mem_in` out N: to `memory.in`; write data.
- `mem_write_en` out 1: to `memory.write_en`; registered.
- `mem_out` in N: from `memory.out`; combinational read data.
- `redirect` in 1: branch/jump taken, one-cycle pulse.
- `redirect_pc` in N: new PC; must be < M.
- `instr_valid` out 1: queue head valid.
- `instr_ready` in 1: decode accepts the head.
- `instr` out N: head instruction word.
- `instr_pc` out N: address the head was fetched from.
- `data_req` in 1: data access request; held high until `data_ack`.
- `data_we` in 1: 1 = store, 0 = load; sampled with `data_req`.
- `data_addr` in N: data address.
- `data_wdata` in N: store data.
- `data_rdata` out N: load result; registered.
- `data_ack` out 1: one-cycle completion pulse; registered.

## Operation
- FSM states: FETCH, DRD, DWR_SETUP, DWR_STROBE, DACK.
- FETCH with `data_req`=1:
  - Latch `data_addr`, `data_wdata` and `data_we` into `addr_q`, `wdata_q` and `we_q`.
  - Go to DRD if `data_we`=0, else DWR_SETUP.
  - No fetch happens this cycle; data has priority over fetch.
- FETCH with `data_req`=0:
  - `mem_address`=pc.
  - If the queue can accept (count<2, or a pop in the same cycle), push {pc, `mem_out`} and set pc ← (pc==M-1) ? 0 : pc+1.
- DRD:
  - `mem_address`=`addr_q`.
  - `data_rdata` ← `mem_out` at end of cycle.
  - Go to DACK.
- DWR_SETUP:
  - `mem_address`=`addr_q`, `mem_in`=`wdata_q`, `mem_write_en`=0.
  - Go to DWR_STROBE.
- DWR_STROBE:
  - `mem_write_en`=1; address and data held.
  - Go to DACK.
- DACK:
  - `data_ack`=1, `mem_write_en`=0; `mem_address`/`mem_in` stay at `addr_q`/`wdata_q`, covering write-strobe hold.
  - `data_req` is ignored this cycle.
  - Go to FETCH.
- `mem_in` = `wdata_q` in all states.
- Queue: 2-entry FIFO of {pc, word}.
  - `instr_valid` = count≠0.
  - Pop on `instr_valid` & `instr_ready`.
  - Push and pop may occur in the same cycle, including when full.
- Redirect has highest priority, in any state:
  - Flush the queue (count←0) and set pc←`redirect_pc`; no push that cycle.
  - An in-flight data op continues unaffected.
- Address 0 reads as 0 (memory behaviour); a word fetched from address 0 is queued as 0.

## Timing
- Reset values:
  - pc=`RESET_PC`, count=0, state FETCH.
  - `instr_valid`=0, `mem_write_en`=0, `data_ack`=0, `data_rdata`=0.
  - `addr_q`=`wdata_q`=0.
- First fetch:
  - First fetch happens in the first cycle after `rst` deasserts.
  - `instr_valid`=1 one cycle later, with `instr_pc`=`RESET_PC`.
- Fetch throughput is 1 word/cycle when `instr_ready`=1 and there is no data traffic.
- Load: `data_req` in cycle T → DRD at T+1 → `data_ack`=1 with valid `data_rdata` at T+2.
- Store: `data_req` in cycle T → setup at T+1 → `mem_write_en` high for exactly T+2 → `data_ack` at T+3.
- Address/data are stable for one full cycle before and after the `mem_write_en` rising edge.
- After a redirect in cycle T:
  - `instr_valid`=0 at T+1.
  - The first word from `redirect_pc` is valid at T+2 if the FSM is in FETCH at T+1.
- Reset mid-operation:
  - Any state returns to FETCH next cycle and `mem_write_en` drops.
  - A write whose strobe has already risen remains committed; no second strobe is issued.
- Full queue with `instr_ready`=0: pc holds, and `mem_address`=pc is re-presented each cycle.

## Test plan
- Reset, `RESET_PC`=4, mem[4..7]=0x1111..0x4444, `instr_ready`=1 → instr sequence 0x1111, 0x2222, 0x3333, 0x4444 with `instr_pc` 4..7 on consecutive cycles, first at cycle 2 after reset release.
- `instr_ready`=0 for 5 cycles → exactly 2 entries held, pc = start+2. Release → no word dropped or duplicated.
- Store 0xBEEF to address 9, then load from 9 → `mem_write_en` high exactly 1 cycle, ack at T+3; load ack at T+2 with `data_rdata`=0xBEEF. No instruction is pushed during either access.
- `redirect` to 0x20 while the queue is full → next valid instr has `instr_pc`=0x20; the old entries are never presented.
- pc=M-1 fetch → next `instr_pc`=0. Load from address 0 → `data_rdata`=0.
- Assert `rst` during DWR_STROBE → `mem_write_en`=0 next cycle, `data_ack` never asserted, state FETCH, pc=`RESET_PC`.
